// File: rtl/exu_lsu.sv
// exu_lsu: load/store unit sitting right after address generation.
// Takes one memory request per handshake, issues it on a single-outstanding
// req/gnt/rsp bus, and returns extended load data with a one-cycle done
// pulse and an error flag (bus error or response timeout).
module exu_lsu #(
  parameter int TO_W   = 8,
  parameter int TO_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_ag4ls_val,
  output logic        hs_ls4ag_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  input  logic [1:0]  i_ls_size,
  input  logic        i_ls_unsg,
  output logic [31:0] o_ls_rdat,
  output logic        o_ls_done,
  output logic        o_ls_err,
  output logic        o_bus_req,
  input  logic        i_bus_gnt,
  output logic [31:0] o_bus_adr,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdat,
  input  logic        i_bus_rsp_val,
  input  logic [31:0] i_bus_rdat,
  input  logic        i_bus_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP, ST_DONE} state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_MAX);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      adr_lo_q, adr_lo_d;
  logic [1:0]      size_q, size_d;
  logic            unsg_q, unsg_d;
  logic            rdy_q, rdy_d;
  logic            req_q, req_d;
  logic [31:0]     bus_adr_q, bus_adr_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdat_q, wdat_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [31:0]     rdat_q, rdat_d;

  logic            is_store;
  logic            accept;
  logic [2:0]      wen_cnt;
  logic [3:0]      enc_be;
  logic [31:0]     enc_wdat;
  logic [31:0]     ext_rdat;
  logic [7:0]      rd_byte [4];

  // Split the raw read word into byte lanes for byte-load selection
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = i_bus_rdat[8*gi +: 8];
  end

  // Command encoding: byte enables and lane-replicated store data
  always_comb begin
    is_store = |i_ls_wen;
    accept   = hs_ag4ls_val & rdy_q & (is_store | i_ls_ren);
    wen_cnt  = {2'b00, i_ls_wen[0]} + {2'b00, i_ls_wen[1]}
             + {2'b00, i_ls_wen[2]} + {2'b00, i_ls_wen[3]};
    enc_wdat = i_ls_wdat;
    enc_be   = 4'b1111;
    if (is_store) begin
      // A store wins over a simultaneous load request
      enc_be = i_ls_wen;
      if (wen_cnt == 3'd1) begin
        enc_wdat = {4{i_ls_wdat[7:0]}};
      end else if (wen_cnt == 3'd2) begin
        enc_wdat = {2{i_ls_wdat[15:0]}};
      end
    end else begin
      case (i_ls_size)
        2'b00:   enc_be = 4'b0001 << i_ls_adr[1:0];
        2'b01:   enc_be = i_ls_adr[1] ? 4'b1100 : 4'b0011;
        default: enc_be = 4'b1111;
      endcase
    end
  end

  // Load data lane selection and sign/zero extension
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rd_byte[adr_lo_q];
    h = adr_lo_q[1] ? i_bus_rdat[31:16] : i_bus_rdat[15:0];
    case (size_q)
      2'b00:   ext_rdat = {{24{b[7] & ~unsg_q}}, b};
      2'b01:   ext_rdat = {{16{h[15] & ~unsg_q}}, h};
      default: ext_rdat = i_bus_rdat;
    endcase
  end

  // Next-state and next-output logic for the IDLE/REQ/RSP/DONE sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_lo_d  = adr_lo_q;
    size_d    = size_q;
    unsg_d    = unsg_q;
    bus_adr_d = bus_adr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdat_d    = wdat_q;
    // Completion outputs are pulses: zero unless set below
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdat_d    = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_REQ;
          adr_lo_d  = i_ls_adr[1:0];
          size_d    = i_ls_size;
          unsg_d    = i_ls_unsg;
          bus_adr_d = {i_ls_adr[31:2], 2'b00};
          we_d      = is_store;
          be_d      = enc_be;
          wdat_d    = enc_wdat;
        end
      end
      ST_REQ: begin
        // Command stays stable on the bus until granted; no timeout here
        if (i_bus_gnt) begin
          state_d = ST_RSP;
          cnt_d   = '0;
        end
      end
      ST_RSP: begin
        // A response arriving on the timeout cycle still takes priority
        if (i_bus_rsp_val) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = i_bus_err;
          rdat_d  = (we_q | i_bus_err) ? 32'd0 : ext_rdat;
        end else if (cnt_q == TO_LIM) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdy_d = (state_d == ST_IDLE);
    req_d = (state_d == ST_REQ);
  end

  // State and registered outputs; async reset drops any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      adr_lo_q  <= 2'b00;
      size_q    <= 2'b00;
      unsg_q    <= 1'b0;
      rdy_q     <= 1'b1;
      req_q     <= 1'b0;
      bus_adr_q <= 32'd0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      wdat_q    <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdat_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_lo_q  <= adr_lo_d;
      size_q    <= size_d;
      unsg_q    <= unsg_d;
      rdy_q     <= rdy_d;
      req_q     <= req_d;
      bus_adr_q <= bus_adr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdat_q    <= wdat_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdat_q    <= rdat_d;
    end
  end

  assign hs_ls4ag_rdy = rdy_q;
  assign o_bus_req    = req_q;
  assign o_bus_adr    = bus_adr_q;
  assign o_bus_we     = we_q;
  assign o_bus_be     = be_q;
  assign o_bus_wdat   = wdat_q;
  assign o_ls_done    = done_q;
  assign o_ls_err     = err_q;
  assign o_ls_rdat    = rdat_q;

endmodule

// File: tb/tb_exu_lsu.sv
// Scoreboard bench for exu_lsu: a driver issues requests and plays the bus,
// pushing expected bus commands and completions; two monitors pop and compare.
module tb_exu_lsu;

  localparam int TO_W   = 8;
  localparam int TO_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs_ag4ls_val = 1'b0;
  logic        hs_ls4ag_rdy;
  logic [31:0] i_ls_adr = '0;
  logic [31:0] i_ls_wdat = '0;
  logic [3:0]  i_ls_wen = '0;
  logic        i_ls_ren = 1'b0;
  logic [1:0]  i_ls_size = '0;
  logic        i_ls_unsg = 1'b0;
  logic [31:0] o_ls_rdat;
  logic        o_ls_done;
  logic        o_ls_err;
  logic        o_bus_req;
  logic        i_bus_gnt = 1'b0;
  logic [31:0] o_bus_adr;
  logic        o_bus_we;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdat;
  logic        i_bus_rsp_val = 1'b0;
  logic [31:0] i_bus_rdat = '0;
  logic        i_bus_err = 1'b0;

  exu_lsu #(.TO_W(TO_W), .TO_MAX(TO_MAX)) dut (
    .clk(clk), .rst(rst),
    .hs_ag4ls_val(hs_ag4ls_val), .hs_ls4ag_rdy(hs_ls4ag_rdy),
    .i_ls_adr(i_ls_adr), .i_ls_wdat(i_ls_wdat), .i_ls_wen(i_ls_wen),
    .i_ls_ren(i_ls_ren), .i_ls_size(i_ls_size), .i_ls_unsg(i_ls_unsg),
    .o_ls_rdat(o_ls_rdat), .o_ls_done(o_ls_done), .o_ls_err(o_ls_err),
    .o_bus_req(o_bus_req), .i_bus_gnt(i_bus_gnt), .o_bus_adr(o_bus_adr),
    .o_bus_we(o_bus_we), .o_bus_be(o_bus_be), .o_bus_wdat(o_bus_wdat),
    .i_bus_rsp_val(i_bus_rsp_val), .i_bus_rdat(i_bus_rdat), .i_bus_err(i_bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdat;
  } bus_exp_t;

  typedef struct packed {
    logic [31:0] rdat;
    logic        err;
    int          cyc;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  done_exp_t d_mon;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte enables straight from the lane rules
  function automatic logic [3:0] ref_be(input logic [31:0] adr, input logic [3:0] wen,
                                        input logic [1:0] size);
    logic [1:0] a;
    a = adr[1:0];
    if (wen != 4'd0) return wen;
    if (size == 2'd0) return 4'(1 << a);
    if (size == 2'd1) return (a >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wdat(input logic [31:0] wdat, input logic [3:0] wen);
    logic [31:0] v;
    v = wdat;
    if ($countones(wen) == 1) v = {wdat[7:0], wdat[7:0], wdat[7:0], wdat[7:0]};
    else if ($countones(wen) == 2) v = {wdat[15:0], wdat[15:0]};
    return v;
  endfunction

  // Reference model: shift the addressed lane down, then extend arithmetically
  function automatic logic [31:0] ref_load(input logic [31:0] adr, input logic [1:0] size,
                                           input logic unsg, input logic [31:0] raw);
    logic [31:0] v;
    int a;
    a = int'(adr[1:0]);
    if (size == 2'd0) begin
      v = (raw >> (8 * a)) & 32'hFF;
      if (!unsg && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (raw >> (16 * (a / 2))) & 32'hFFFF;
      if (!unsg && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  // Bus monitor: every request cycle must match the queued command; pop on grant
  always @(negedge clk) begin
    if (!rst && o_bus_req) begin
      if (bus_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bus_req actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        chk("bus_adr", o_bus_adr, bus_q[0].adr);
        chk("bus_we", 32'(o_bus_we), 32'(bus_q[0].we));
        chk("bus_be", 32'(o_bus_be), 32'(bus_q[0].be));
        chk("bus_wdat", o_bus_wdat, bus_q[0].wdat);
        if (i_bus_gnt) void'(bus_q.pop_front());
      end
    end
  end

  // Completion monitor: done pulses pop the scoreboard; otherwise outputs must be zero
  always @(negedge clk) begin
    if (!rst) begin
      if (o_ls_done) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          d_mon = done_q.pop_front();
          chk("done_rdat", o_ls_rdat, d_mon.rdat);
          chk("done_err", 32'(o_ls_err), 32'(d_mon.err));
          chk("done_cycle", 32'(cyc), 32'(d_mon.cyc));
          chk("rdy_in_done", 32'(hs_ls4ag_rdy), 32'd0);
        end
      end else begin
        chk("idle_rdat_err", {o_ls_rdat[31:1], o_ls_rdat[0] | o_ls_err}, 32'd0);
      end
    end
  end

  // Issue one request and play the bus; tmo means no response is ever given
  task automatic run_txn(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] wen,
                         input logic ren, input logic [1:0] size, input logic unsg,
                         input int g, input int r, input bit tmo,
                         input logic [31:0] brdat, input logic berr);
    int waitc;
    int acc;
    bus_exp_t be_e;
    done_exp_t de;
    waitc = 0;
    while (!hs_ls4ag_rdy && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!hs_ls4ag_rdy) begin
      checks++;
      failures++;
      $display("FAIL rdy_wait actual=0 required=1 (cycle %0d)", cyc);
      return;
    end
    hs_ag4ls_val = 1'b1;
    i_ls_adr = adr; i_ls_wdat = wdat; i_ls_wen = wen;
    i_ls_ren = ren; i_ls_size = size; i_ls_unsg = unsg;
    @(posedge clk); #1;
    hs_ag4ls_val = 1'b0;
    acc = cyc;
    if (wen == 4'd0 && !ren) begin
      $display("txn noop adr=%h", adr);
      chk("noop_stays_idle", 32'(hs_ls4ag_rdy), 32'd1);
      return;
    end
    be_e.adr  = {adr[31:2], 2'b00};
    be_e.we   = (wen != 4'd0);
    be_e.be   = ref_be(adr, wen, size);
    be_e.wdat = (wen != 4'd0) ? ref_wdat(wdat, wen) : wdat;
    bus_q.push_back(be_e);
    if (tmo) begin
      de.rdat = 32'd0;
      de.err  = 1'b1;
      de.cyc  = acc + g + 2 + TO_MAX;
    end else begin
      de.err  = berr;
      de.rdat = (berr || wen != 4'd0) ? 32'd0 : ref_load(adr, size, unsg, brdat);
      de.cyc  = acc + g + 2 + r;
    end
    done_q.push_back(de);
    $display("txn adr=%h wen=%b ren=%0d size=%0d unsg=%0d gnt_dly=%0d rsp_dly=%0d tmo=%0d berr=%0d exp_rdat=%h exp_err=%0d",
             adr, wen, ren, size, unsg, g, r, tmo, berr, de.rdat, de.err);
    repeat (g) begin @(posedge clk); #1; end
    i_bus_gnt = 1'b1;
    @(posedge clk); #1;
    i_bus_gnt = 1'b0;
    if (tmo) begin
      repeat (TO_MAX + 1) begin @(posedge clk); #1; end
      // Stale response during DONE and IDLE must be ignored
      i_bus_rsp_val = 1'b1; i_bus_rdat = brdat; i_bus_err = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_bus_rsp_val = 1'b0;
    end else begin
      repeat (r) begin @(posedge clk); #1; end
      i_bus_rsp_val = 1'b1; i_bus_rdat = brdat; i_bus_err = berr;
      @(posedge clk); #1;
      i_bus_rsp_val = 1'b0; i_bus_err = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] adr, wdat, brdat;
    logic [3:0]  wen;
    logic        ren, unsg, berr;
    logic [1:0]  size;
    int          kind;
    bit          tmo;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", 32'(hs_ls4ag_rdy), 32'd1);
    chk("reset_req", 32'(o_bus_req), 32'd0);
    chk("reset_done", 32'(o_ls_done), 32'd0);
    chk("reset_err", 32'(o_ls_err), 32'd0);
    chk("reset_rdat", o_ls_rdat, 32'd0);
    chk("reset_bus_adr", o_bus_adr, 32'd0);
    chk("reset_bus_be_we", {27'd0, o_bus_we, o_bus_be}, 32'd0);
    chk("reset_bus_wdat", o_bus_wdat, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_txn(32'h100, 32'h0, 4'b0000, 1'b1, 2'b10, 1'b0, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0);
    run_txn(32'h103, 32'h0, 4'b0000, 1'b1, 2'b00, 1'b0, 0, 0, 1'b0, 32'h80112233, 1'b0);
    run_txn(32'h103, 32'h0, 4'b0000, 1'b1, 2'b00, 1'b1, 0, 0, 1'b0, 32'h80112233, 1'b0);
    run_txn(32'h202, 32'h0000ABCD, 4'b1100, 1'b0, 2'b00, 1'b0, 3, 1, 1'b0, 32'h0, 1'b0);
    run_txn(32'h302, 32'h00008001, 4'b0000, 1'b1, 2'b01, 1'b0, 1, 2, 1'b0, 32'h8001FFFF, 1'b0);
    run_txn(32'h400, 32'h0, 4'b0000, 1'b1, 2'b10, 1'b0, 0, 0, 1'b1, 32'h12345678, 1'b0);
    run_txn(32'h404, 32'h0, 4'b0000, 1'b1, 2'b11, 1'b0, 0, TO_MAX, 1'b0, 32'hCAFEF00D, 1'b0);
    run_txn(32'h501, 32'h000000A5, 4'b0010, 1'b1, 2'b10, 1'b0, 0, 0, 1'b0, 32'hFFFFFFFF, 1'b0);
    run_txn(32'h600, 32'h0, 4'b0000, 1'b0, 2'b10, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    run_txn(32'h700, 32'h0, 4'b0000, 1'b1, 2'b10, 1'b0, 0, 0, 1'b0, 32'h55555555, 1'b1);
    chk("rdy_low_in_done", 32'(hs_ls4ag_rdy), 32'd0);
    @(posedge clk); #1;
    chk("rdy_after_done", 32'(hs_ls4ag_rdy), 32'd1);
    run_txn(32'h704, 32'h0, 4'b0000, 1'b1, 2'b01, 1'b1, 0, 0, 1'b0, 32'hBEEF1234, 1'b0);

    // Reset while waiting for a response
    @(posedge clk); #1;
    hs_ag4ls_val = 1'b1; i_ls_adr = 32'h800; i_ls_wen = 4'b0000; i_ls_ren = 1'b1;
    i_ls_size = 2'b10; i_ls_unsg = 1'b0;
    bus_q.push_back('{adr: 32'h800, we: 1'b0, be: 4'b1111, wdat: i_ls_wdat});
    @(posedge clk); #1;
    hs_ag4ls_val = 1'b0;
    i_bus_gnt = 1'b1;
    @(posedge clk); #1;
    i_bus_gnt = 1'b0;
    $display("txn reset_in_rsp adr=00000800");
    rst = 1'b1;
    #1;
    chk("rst_rdy", 32'(hs_ls4ag_rdy), 32'd1);
    chk("rst_req", 32'(o_bus_req), 32'd0);
    chk("rst_done", 32'(o_ls_done), 32'd0);
    i_bus_rsp_val = 1'b1; i_bus_rdat = 32'h01020304;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_bus_rsp_val = 1'b0;
    chk("rdy_after_rst", 32'(hs_ls4ag_rdy), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      kind  = int'($urandom_range(0, 9));
      size  = 2'($urandom_range(0, 3));
      adr   = $urandom;
      wdat  = $urandom;
      brdat = $urandom;
      unsg  = 1'($urandom_range(0, 1));
      berr  = ($urandom_range(0, 6) == 0);
      tmo   = ($urandom_range(0, 9) == 0);
      if (size == 2'd1) adr[0] = 1'b0;
      if (size >= 2'd2) adr[1:0] = 2'b00;
      if (kind < 5) begin
        wen = 4'd0; ren = 1'b1;
      end else if (kind < 9) begin
        wen = 4'($urandom_range(1, 15)); ren = 1'($urandom_range(0, 1));
      end else begin
        wen = 4'd0; ren = 1'b0;
      end
      run_txn(adr, wdat, wen, ren, size, unsg, int'($urandom_range(0, 3)),
              int'($urandom_range(0, TO_MAX)), tmo, brdat, berr);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
